// File: rtl/ipu_grid_input.sv
// ipu_grid_input: synchronizes and debounces the nine tic-tac-toe cell buttons,
// encodes a single stable press into a 4-bit cell index, strobes it into the
// grid_coord register and raises an interrupt that is held until acknowledged.
module ipu_grid_input #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] btn,
    input  logic       int_ack,
    output logic       write_en,
    output logic [3:0] coord_out,
    output logic       ipu_int,
    output logic       multi_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_INT,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [8:0]       r_sync1;
    logic [8:0]       r_sync2;
    logic [8:0]       r_prev;
    logic [8:0]       r_db;
    logic [CNT_W-1:0] r_cnt;

    state_t           r_state;
    state_t           w_next;

    logic             w_onehot;
    logic             w_multi;
    logic [3:0]       w_index;

    logic             w_write_en_d;
    logic             w_ipu_int_d;
    logic             w_multi_err_d;
    logic             w_busy_d;
    logic             w_coord_load;

    logic             r_write_en;
    logic [3:0]       r_coord;
    logic             r_ipu_int;
    logic             r_multi_err;
    logic             r_busy;

    // Two-flop synchronizer per button bit.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept the synchronized vector once it has been unchanged long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
            r_cnt  <= '0;
            r_db   <= '0;
        end else begin
            r_prev <= r_sync2;
            if (r_sync2 != r_prev) begin
                r_cnt <= '0;
            end else if (r_cnt != DB_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_sync2 == r_prev) && (r_cnt == DB_LAST)) begin
                r_db <= r_sync2;
            end
        end
    end

    // Classify the debounced vector and encode the set bit to a cell index.
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        w_onehot = $onehot(r_db);
        w_multi  = (r_db != '0) && !w_onehot;
        w_index  = 4'hF;
        for (int i = 0; i < 9; i++) begin
            if (r_db[i]) begin
                w_index = 4'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic: at most one request outstanding, buttons ignored once busy.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_next = S_WRITE;
                end else if (w_multi) begin
                    w_next = S_RELEASE;
                end
            end
            S_WRITE:   w_next = S_INT;
            S_INT:     if (int_ack) w_next = S_RELEASE;
            S_RELEASE: if (r_db == '0) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs, keyed on the state being entered.
    always_comb begin
        w_write_en_d  = (w_next == S_WRITE);
        w_ipu_int_d   = (w_next == S_INT);
        w_busy_d      = (w_next != S_IDLE);
        w_multi_err_d = (r_state == S_IDLE) && w_multi;
        w_coord_load  = (r_state == S_IDLE) && w_onehot;
    end

    // Output registers; coord holds the last written index until the next write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write_en  <= 1'b0;
            r_coord     <= 4'hF;
            r_ipu_int   <= 1'b0;
            r_multi_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_write_en  <= w_write_en_d;
            r_ipu_int   <= w_ipu_int_d;
            r_multi_err <= w_multi_err_d;
            r_busy      <= w_busy_d;
            if (w_coord_load) begin
                r_coord <= w_index;
            end
        end
    end

    assign write_en  = r_write_en;
    assign coord_out = r_coord;
    assign ipu_int   = r_ipu_int;
    assign multi_err = r_multi_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ipu_grid_input.sv
// Testbench for ipu_grid_input: directed scenarios followed by randomized
// presses, every cycle compared against a behavioural reference model.
module tb_ipu_grid_input;

    localparam int DB = 16;

    logic       clk;
    logic       rst;
    logic [8:0] btn;
    logic       int_ack;
    logic       write_en;
    logic [3:0] coord_out;
    logic       ipu_int;
    logic       multi_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ipu_grid_input #(
        .DB_CYCLES(DB),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .int_ack  (int_ack),
        .write_en (write_en),
        .coord_out(coord_out),
        .ipu_int  (ipu_int),
        .multi_err(multi_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Buttons reach the debouncer two edges late; a vector is accepted once
    // the same value has been seen at DB+1 consecutive edges.  The request
    // flow is tracked as "write pending", "interrupt raised" and "waiting
    // for all buttons released".
    logic [8:0] m_q1, m_s, m_last, m_db;
    int         m_run;
    logic       m_write_en, m_int, m_busy, m_multi, m_hold;
    logic [3:0] m_coord;

    function automatic logic [3:0] cell_of(input logic [8:0] v);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 0; i < 9; i++) if (v[i]) c = 4'(i);
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q1 <= '0; m_s <= '0; m_last <= '0; m_db <= '0; m_run <= 1;
            m_write_en <= 1'b0; m_int <= 1'b0; m_busy <= 1'b0;
            m_multi <= 1'b0; m_hold <= 1'b0; m_coord <= 4'hF;
        end else begin
            m_q1   <= btn;
            m_s    <= m_q1;
            m_last <= m_s;
            if (m_s == m_last) begin
                if (m_run < 1000000) m_run <= m_run + 1;
                if (m_run >= DB) m_db <= m_s;
            end else begin
                m_run <= 1;
            end
            m_multi <= 1'b0;
            if (!m_busy) begin
                if ($countones(m_db) == 1) begin
                    m_write_en <= 1'b1; m_busy <= 1'b1; m_coord <= cell_of(m_db);
                end else if (m_db != '0) begin
                    m_multi <= 1'b1; m_busy <= 1'b1; m_hold <= 1'b1;
                end
            end else if (m_write_en) begin
                m_write_en <= 1'b0; m_int <= 1'b1;
            end else if (m_int) begin
                if (int_ack) begin
                    m_int <= 1'b0; m_hold <= 1'b1;
                end
            end else if (m_hold && m_db == '0) begin
                m_hold <= 1'b0; m_busy <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        check("write_en",  32'(write_en),  32'(m_write_en));
        check("coord_out", 32'(coord_out), 32'(m_coord));
        check("ipu_int",   32'(ipu_int),   32'(m_int));
        check("multi_err", 32'(multi_err), 32'(m_multi));
        check("busy",      32'(busy),      32'(m_busy));
    endtask

    // One clock: outputs sampled on the falling edge, then compared to the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_write(input int budget, output int k);
        k = 0;
        while (write_en !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("write_seen", 32'(write_en), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // Acknowledge a raised interrupt, release buttons and return to idle.
    task automatic ack_release();
        int_ack = 1'b1;
        tick();
        check("ack_drop", 32'(ipu_int), 32'd0);
        int_ack = 1'b0;
        btn     = '0;
        wait_idle(80);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         k, n_wr, n_int, n_multi, kind, hold, a, b, reps;
        logic [8:0] v;

        rst = 1'b0; btn = '0; int_ack = 1'b0;
        @(negedge clk);
        // Reset held for three cycles, then a long idle stretch
        for (int i = 0; i < 3; i++) tick();
        check("rst_coord", 32'(coord_out), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_wr += int'(write_en | ipu_int | multi_err | busy);
        end
        check("idle_activity", 32'(n_wr), 32'd0);
        check("idle_coord", 32'(coord_out), 32'hF);

        // Clean press of cell 4: 2 sync + 16 debounce + 1 FSM edge after the first sampling edge
        btn = 9'h010;
        wait_write(60, k);
        check("press_latency", 32'(k), 32'd20);
        check("press_coord", 32'(coord_out), 32'd4);
        tick();
        check("press_write_one_cycle", 32'(write_en), 32'd0);
        check("press_int_rise", 32'(ipu_int), 32'd1);
        int_ack = 1'b1;
        tick();
        check("press_int_fall", 32'(ipu_int), 32'd0);
        check("press_busy_held", 32'(busy), 32'd1);
        int_ack = 1'b0;
        btn = '0;
        wait_idle(80);

        // Bounce on cell 2: toggling every 5 cycles never passes the debouncer
        n_wr = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 5 == 0) btn = btn ^ 9'h004;
            tick();
            n_wr += int'(write_en);
        end
        check("bounce_no_write", 32'(n_wr), 32'd0);
        btn = 9'h004;
        wait_write(60, k);
        check("bounce_coord", 32'(coord_out), 32'd2);
        tick();
        ack_release();

        // Two cells at once: single error pulse, no write, coord untouched
        btn = 9'h101;
        n_wr = 0; n_int = 0; n_multi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_wr += int'(write_en); n_int += int'(ipu_int); n_multi += int'(multi_err);
        end
        check("multi_pulses", 32'(n_multi), 32'd1);
        check("multi_no_write", 32'(n_wr), 32'd0);
        check("multi_no_int", 32'(n_int), 32'd0);
        check("multi_coord", 32'(coord_out), 32'd2);
        btn = '0;
        wait_idle(80);
        btn = 9'h100;
        wait_write(60, k);
        check("cell8_coord", 32'(coord_out), 32'd8);
        tick();
        ack_release();

        // Held press with ack tied high: one write, interrupt high for one cycle, no retrigger
        int_ack = 1'b1;
        btn = 9'h001;
        n_wr = 0; n_int = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_wr += int'(write_en); n_int += int'(ipu_int);
        end
        check("held_writes", 32'(n_wr), 32'd1);
        check("held_int_cycles", 32'(n_int), 32'd1);
        check("held_coord", 32'(coord_out), 32'd0);
        int_ack = 1'b0;
        btn = '0;
        wait_idle(80);
        btn = 9'h001;
        wait_write(60, k);
        check("repress_coord", 32'(coord_out), 32'd0);
        tick();
        ack_release();

        // Reset while the interrupt is pending, then a fresh write with the button still held
        btn = 9'h020;
        wait_write(60, k);
        tick();
        check("pre_reset_int", 32'(ipu_int), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_int", 32'(ipu_int), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_coord", 32'(coord_out), 32'hF);
        tick();
        tick();
        rst = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_wr += int'(write_en);
        end
        check("post_reset_writes", 32'(n_wr), 32'd1);
        check("post_reset_coord", 32'(coord_out), 32'd5);
        check("post_reset_int", 32'(ipu_int), 32'd1);
        ack_release();

        // Randomized presses, glitches, bounces and multi-presses with random acks
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 8));
            b = (a + 1 + int'($urandom_range(0, 7))) % 9;
            v = 9'h001 << a;
            if (kind == 1) v = v | (9'h001 << b) | 9'($urandom);
            if (kind == 2) begin
                reps = int'($urandom_range(2, 6));
                for (int j = 0; j < reps; j++) begin
                    btn = v;
                    hold = int'($urandom_range(1, 12));
                    for (int c = 0; c < hold; c++) begin
                        int_ack = ($urandom_range(0, 3) == 0);
                        tick();
                    end
                    btn = '0;
                    hold = int'($urandom_range(1, 12));
                    for (int c = 0; c < hold; c++) begin
                        int_ack = ($urandom_range(0, 3) == 0);
                        tick();
                    end
                end
            end
            if (kind == 3) begin
                btn = v;
                hold = int'($urandom_range(1, 14));
            end else begin
                btn = v;
                hold = int'($urandom_range(20, 60));
            end
            for (int c = 0; c < hold; c++) begin
                int_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
            btn = '0;
            for (int c = 0; c < 40; c++) begin
                int_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        int_ack = 1'b0;
        for (int c = 0; c < 60; c++) begin
            int_ack = (c == 10);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipu_grid_input.md
Name: ipu_grid_input

Overview:
- Input processing unit that sits directly upstream of the grid_coord register and the processor interrupt input.
- Takes the nine raw tic-tac-toe cell buttons, synchronizes and debounces them, and encodes a single valid press to a 4-bit cell index.
- Writes that index into grid_coord with a one-cycle write strobe, then raises ipu_int and holds it until the processor returns int_ack.

Parameters:
- DB_CYCLES, 16, consecutive cycles the synchronized button vector must be unchanged before it is accepted (legal range 2 to 65535).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- btn  input  9  raw asynchronous cell buttons, active-high; bit i = cell i (row-major, 0..8)
- int_ack  input  1  processor interrupt acknowledge, level, sampled on clk
- write_en  output  1  one-cycle strobe to grid_coord write_en
- coord_out  output  4  cell index to grid_coord coord_in; valid while write_en=1, held afterwards
- ipu_int  output  1  interrupt request to processor
- multi_err  output  1  one-cycle pulse: stable vector had more than one bit set
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): write_en=0, coord_out=4'hF (no-cell sentinel), ipu_int=0, multi_err=0, busy=0. Synchronizer flops, sampled vector and db_btn clear to 0, counter to 0, FSM to IDLE. Reset asserted in any state, including INT, aborts immediately; no write or interrupt is replayed.
- Synchronizer: 2-flop per bit, producing s_btn.
- Debounce:
  - If s_btn differs from the previously sampled vector, counter=0.
  - Otherwise the counter increments, saturating at DB_CYCLES.
  - When the counter reaches DB_CYCLES-1 while unchanged, db_btn<=s_btn.
  - db_btn therefore updates DB_CYCLES cycles after s_btn settles. Glitches shorter than DB_CYCLES never reach db_btn.
- FSM states: IDLE, WRITE, INT, RELEASE. All outputs are registered.
  - IDLE:
    - db_btn one-hot -> WRITE; coord_out<=index of the set bit (0..8).
    - db_btn has two or more bits set -> multi_err=1 for one cycle, go to RELEASE; no write, no interrupt.
    - db_btn==0 -> stay in IDLE.
  - WRITE: write_en=1 for exactly this one cycle -> INT.
  - INT:
    - ipu_int=1.
    - If int_ack is sampled high on an edge, ipu_int=0 from the next cycle and the FSM goes to RELEASE.
    - No timeout; ipu_int is held indefinitely.
  - RELEASE: waits until db_btn==0, then goes to IDLE. A press held through ack therefore never retriggers.
- Latency: db_btn becomes one-hot at edge t -> write_en=1 in cycle t+1 -> ipu_int=1 from t+2.
- int_ack outside INT is ignored. int_ack already high on INT entry means ipu_int is high for exactly one cycle.
- Button changes while in WRITE, INT or RELEASE are ignored; at most one request is outstanding.
- coord_out holds the last written index until the next WRITE. It never changes while ipu_int=1.
- busy = (state != IDLE).

Test Plan:
- Reset then idle: rst=0 for 3 cycles, btn=0 for 50 cycles -> coord_out=4'hF, write_en=ipu_int=multi_err=busy=0 throughout.
- Clean press (DB_CYCLES=16): btn=9'h010 held -> write_en=1 for exactly one cycle, 2 (sync) + 16 cycles after the btn edge plus one FSM cycle, with coord_out=4'd4. ipu_int rises the next cycle. With int_ack=1 for one cycle, ipu_int=0 on the following cycle. Releasing btn returns busy to 0.
- Bounce rejection: btn bit 2 toggled every 5 cycles for 60 cycles, then held -> no write_en during toggling; one write with coord_out=4'd2 after it settles.
- Multi-press: btn=9'h101 held -> multi_err pulses once, no write_en or ipu_int, coord_out unchanged. After release, btn=9'h100 -> write with coord_out=4'd8.
- Held press and early ack: btn=9'h001 held for 200 cycles, int_ack tied high -> exactly one write_en (coord 0) and ipu_int high for one cycle, with no retrigger until btn returns to 0 and is pressed again.
- Reset mid-operation: assert rst=0 during INT -> ipu_int and busy drop asynchronously and coord_out=4'hF. After rst=1 with btn still held, one fresh debounced write occurs.
